// File: rtl/strided_buffer_writer.sv
// Fills the column-interleaved feature-map banks from a raster-order beat stream.
// Optional STRIDED_BUF_WR_BOUND_CHECK_EN: drop out-of-range writes and raise a sticky err.
module strided_buffer_writer #(
  parameter int N_BUF_X    = 10,
  parameter int B_BUF_ADDR = 9,
  parameter int B_SHAPE    = 25,
  parameter int DATA_WIDTH = 64,
  parameter int B_ACC      = 18
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [B_SHAPE-1:0]             ftm_shape,
  input  logic [DATA_WIDTH-1:0]          s_tdata,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic [N_BUF_X-1:0]             wr_en,
  output logic [B_BUF_ADDR*N_BUF_X-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  localparam int XW = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;

  typedef enum logic [1:0] {IDLE, CALC, LOAD, DONE} state_t;
  state_t state;

  logic [8:0]            w_q, h_q, x, y;
  logic [6:0]            n_q, k, c;
  logic [XW-1:0]         x_rem;
  logic [B_ACC-1:0]      col_step, col_base, row_base;
  logic [B_BUF_ADDR-1:0] addr;
  logic                  ovf, last_c, last_x, last_y;

`ifdef STRIDED_BUF_WR_BOUND_CHECK_EN
  logic [B_ACC-1:0] addr_full;
  assign addr_full = row_base + col_base + B_ACC'(c);
  assign addr      = addr_full[B_BUF_ADDR-1:0];
  assign ovf       = |addr_full[B_ACC-1:B_BUF_ADDR];
`else
  assign addr = B_BUF_ADDR'(row_base + col_base + B_ACC'(c));
  assign ovf  = 1'b0;
  assign err  = 1'b0;
`endif

  assign last_c = (c == n_q - 7'd1);
  assign last_x = (x == w_q - 9'd1);
  assign last_y = (y == h_q - 9'd1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      n_q      <= '0;
      k        <= '0;
      c        <= '0;
      x        <= '0;
      x_rem    <= '0;
      y        <= '0;
      col_step <= '0;
      col_base <= '0;
      row_base <= '0;
      s_tready <= 1'b0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef STRIDED_BUF_WR_BOUND_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      wr_en   <= '0;
      wr_addr <= '0;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          w_q      <= ftm_shape[8:0];
          h_q      <= ftm_shape[17:9];
          n_q      <= ftm_shape[24:18];
          col_step <= '0;
          k        <= '0;
          c        <= '0;
          x        <= '0;
          x_rem    <= '0;
          y        <= '0;
          col_base <= '0;
          row_base <= '0;
          busy     <= 1'b1;
          if (ftm_shape[8:0] == 9'd0 || ftm_shape[17:9] == 9'd0 || ftm_shape[24:18] == 7'd0)
            state <= DONE;
          else
            state <= CALC;
        end
        // col_step = n*h by repeated addition, one add per cycle
        CALC: begin
          col_step <= col_step + B_ACC'(h_q);
          k        <= k + 7'd1;
          if (k == n_q - 7'd1) begin
            state    <= LOAD;
            s_tready <= 1'b1;
          end
        end
        LOAD: if (s_tvalid) begin
          wr_data <= s_tdata;
          if (!ovf) begin
            wr_en[x_rem]                            <= 1'b1;
            wr_addr[x_rem*B_BUF_ADDR +: B_BUF_ADDR] <= addr;
          end
`ifdef STRIDED_BUF_WR_BOUND_CHECK_EN
          else err <= 1'b1;
`endif
          if (!last_c) begin
            c <= c + 7'd1;
          end else begin
            c <= '0;
            if (last_x) begin
              x        <= '0;
              x_rem    <= '0;
              col_base <= '0;
              row_base <= row_base + B_ACC'(n_q);
              y        <= y + 9'd1;
            end else begin
              x <= x + 9'd1;
              if (x_rem == XW'(N_BUF_X - 1)) begin
                x_rem    <= '0;
                col_base <= col_base + col_step;
              end else begin
                x_rem <= x_rem + XW'(1);
              end
            end
          end
          if (last_c && last_x && last_y) begin
            state    <= DONE;
            s_tready <= 1'b0;
            done     <= 1'b1;
          end
        end
        // Entered from LOAD with done already pulsing; from the empty-shape path it pulses here.
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_strided_buffer_writer.sv
// Randomized fills of strided_buffer_writer checked against an arithmetic bank/address model.
module tb_strided_buffer_writer;
  localparam int N  = 10;
  localparam int BA = 9;
  localparam int DW = 64;
`ifdef STRIDED_BUF_WR_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic [24:0]     ftm_shape = '0;
  logic [DW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic [N-1:0]    wr_en;
  logic [BA*N-1:0] wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy, done, err;

  strided_buffer_writer #(.N_BUF_X(N), .B_BUF_ADDR(BA), .B_SHAPE(25), .DATA_WIDTH(DW), .B_ACC(18)) dut (
    .clk(clk), .rstn(rstn), .start(start), .ftm_shape(ftm_shape),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  err_exp = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one fill; poke_at = beat count at which a stray start is issued, reset_at = beats before reset.
  task automatic run_fill(input int w, input int h, input int n, input bit rnd_valid,
                          input int poke_at, input int reset_at);
    int total, beats, cyc, budget, wr_seen, wr_exp;
    int b, c, x, y, bank, full;
    bit pend, pend_done, pend_ovf;
    logic [N-1:0]    pend_en;
    logic [BA*N-1:0] pend_addr;
    logic [DW-1:0]   pend_data;
    total = w * h * n;
    ftm_shape = {7'(n), 9'(h), 9'(w)};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ftm_shape = $urandom;
    if (total == 0) begin
      check("zero_done_early", done, 0);
      check("zero_busy", busy, 1);
      @(negedge clk);
      check("zero_done", done, 1);
      check("zero_wr_en", wr_en, 0);
      check("zero_tready", s_tready, 0);
      @(negedge clk);
      check("zero_done_end", done, 0);
      check("zero_busy_end", busy, 0);
      return;
    end
    for (int j = 0; j < n; j++) begin
      check("calc_tready", s_tready, 0);
      check("calc_busy", busy, 1);
      @(negedge clk);
    end
    beats = 0; cyc = 0; wr_seen = 0; wr_exp = 0;
    budget = total * 4 + 20;
    pend = 0; pend_done = 0; pend_ovf = 0;
    pend_en = '0; pend_addr = '0; pend_data = '0;
    forever begin
      if (pend && pend_ovf) err_exp = 1'b1;
      if (pend) begin
        check("wr_en", wr_en, pend_en);
        check("wr_addr", wr_addr, pend_addr);
        if (pend_en != 0) check("wr_data", wr_data, pend_data);
      end else begin
        check("wr_idle", wr_en, 0);
      end
      check("done", done, pend_done);
      check("err", err, err_exp);
      if (wr_en != 0) wr_seen++;
      if (pend_done) break;
      if (reset_at > 0 && beats == reset_at) begin
        rstn = 1'b0; s_tvalid = 1'b0;
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_tready", s_tready, 0);
        check("rst_err", err, 0);
        rstn = 1'b1; err_exp = 1'b0;
        return;
      end
      check("tready", s_tready, 1);
      if (beats == poke_at) begin
        start = 1'b1;
        ftm_shape = {7'd3, 9'd2, 9'd5};
      end
      s_tvalid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata  = {$urandom, $urandom};
      pend = 0; pend_done = 0; pend_ovf = 0;
      if (s_tvalid) begin
        b    = beats;
        c    = b % n;
        x    = (b / n) % w;
        y    = b / (n * w);
        bank = x % N;
        full = n * (y + h * (x / N)) + c;
        pend = 1;
        pend_data = s_tdata;
        pend_en = '0; pend_addr = '0;
        if (BOUND && full >= (1 << BA)) begin
          pend_ovf = 1;
        end else begin
          pend_en[bank] = 1'b1;
          pend_addr[bank*BA +: BA] = BA'(full);
          wr_exp++;
        end
        beats++;
        pend_done = (beats == total);
      end
      cyc++;
      if (cyc > budget) begin
        check("timeout", 0, 1);
        s_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
      start = 1'b0;
    end
    // Extra beat offered after the last one must not be taken
    s_tvalid = 1'b1;
    check("post_tready", s_tready, 0);
    @(negedge clk);
    s_tvalid = 1'b0;
    check("post_wr_en", wr_en, 0);
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("wr_count", wr_seen, wr_exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tready", s_tready, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_fill(12, 3, 2, 1'b0, -1, 0);
    run_fill(12, 3, 2, 1'b1, -1, 0);
    run_fill(0, 3, 2, 1'b0, -1, 0);
    run_fill(12, 0, 2, 1'b0, -1, 0);
    run_fill(12, 3, 0, 1'b0, -1, 0);
    run_fill(12, 3, 2, 1'b0, 20, 0);
    run_fill(12, 3, 2, 1'b1, -1, 30);
    run_fill(12, 3, 2, 1'b0, -1, 0);
    run_fill(1, 300, 2, 1'b0, -1, 0);
    for (int i = 0; i < 6; i++)
      run_fill($urandom_range(1, 25), $urandom_range(1, 8), $urandom_range(1, 5), 1'b1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
